intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 27 ++
 rtl/intr_prio_enc.sv | 21 ++
 rtl/intr_ctrl.sv | 157 +++++++++++++++
 tb/tb_intr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl shared constants: CP0 register map, FSM encodings,
// interrupt vector base and Status field positions.
package intr_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ENTER   = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_RETURN  = 3'd4;

  localparam logic [31:0] VEC_BASE = 32'h0000_0800;

  localparam int IE_BIT = 0;
  localparam int IM_LSB = 8;
  localparam int IM_W   = 4;

  function automatic logic [31:0] vec_addr(
    input logic [1:0] src
  );
    return VEC_BASE + {26'd0, src, 4'd0};
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: 4-bit lowest-set-bit priority encoder.
// Bit 0 has the highest priority.
module intr_prio_enc (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 2'd0;
    valid = |req;
    priority case (1'b1)
      req[0]:  idx = 2'd0;
      req[1]:  idx = 2'd1;
      req[2]:  idx = 2'd2;
      req[3]:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: CP0 Status/Cause/EPC plus interrupt entry/return FSM.
// Define INTR_VECTORED_EN for per-source handler vectors.
module intr_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  IntReq,
  input  logic        Stall,
  input  logic [31:0] ID_PC,
  input  logic        ID_InDelay,
  input  logic        mtc0,
  input  logic        eret,
  input  logic [4:0]  CP0_Addr,
  input  logic [31:0] CP0_WData,
  output logic [31:0] CP0_RData,
  output logic        IntFlush,
  output logic        PCRedirect,
  output logic [31:0] RedirectPC,
  output logic        InHandler
);
  import intr_ctrl_pkg::*;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        ie;
  logic [3:0]  im;
  logic [31:0] epc;
  logic [31:0] redirect_q;
  logic        in_handler;

  logic [3:0]  masked;
  logic [1:0]  src_idx;
  logic        src_vld;
  logic        pending;
  logic        go;
  logic        is_enter;
  logic        is_return;
  logic [31:0] enter_pc;

  assign masked = IntReq & im;

  intr_prio_enc u_enc (
    .req   (masked),
    .idx   (src_idx),
    .valid (src_vld)
  );

  assign pending   = ie & ~in_handler & src_vld;
  assign go        = ~Stall & ~ID_InDelay & ~mtc0;
  assign is_enter  = (state == ST_ENTER);
  assign is_return = (state == ST_RETURN);

`ifdef INTR_VECTORED_EN
  logic [1:0] src_q;
  logic       unused_src_q;

  assign enter_pc     = vec_addr(src_idx);
  assign unused_src_q = ^src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= 2'd0;
    end else if (is_enter) begin
      src_q <= src_idx;
    end
  end
`else
  logic unused_src;

  assign enter_pc   = VEC_BASE;
  assign unused_src = ^src_idx;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nxt = ST_WAIT;
        end else if (eret && !Stall) begin
          state_nxt = ST_RETURN;
        end
      end
      ST_WAIT: begin
        if (!pending) begin
          state_nxt = ST_IDLE;
        end else if (go) begin
          state_nxt = ST_ENTER;
        end
      end
      ST_ENTER: state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        if (eret && !Stall) begin
          state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ENTER/RETURN own IE and EPC, so mtc0 is dropped in those cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ie         <= 1'b0;
      im         <= 4'd0;
      epc        <= 32'd0;
      redirect_q <= 32'd0;
      in_handler <= 1'b0;
    end else begin
      state <= state_nxt;
      if (is_enter) begin
        epc        <= ID_PC;
        ie         <= 1'b0;
        in_handler <= 1'b1;
        redirect_q <= enter_pc;
      end else if (is_return) begin
        ie         <= 1'b1;
        in_handler <= 1'b0;
        redirect_q <= epc;
      end else if (mtc0) begin
        if (CP0_Addr == CP0_STATUS) begin
          ie <= CP0_WData[IE_BIT];
          im <= CP0_WData[IM_LSB +: IM_W];
        end else if (CP0_Addr == CP0_EPC) begin
          epc <= CP0_WData;
        end
      end
    end
  end

  always_comb begin
    CP0_RData = 32'd0;
    case (CP0_Addr)
      CP0_STATUS: begin
        CP0_RData[IE_BIT]             = ie;
        CP0_RData[IM_LSB +: IM_W]     = im;
      end
      CP0_CAUSE: CP0_RData[IM_LSB +: IM_W] = IntReq;
      CP0_EPC:   CP0_RData = epc;
      default:   CP0_RData = 32'd0;
    endcase
  end

  always_comb begin
    IntFlush   = is_enter | is_return;
    PCRedirect = is_enter | is_return;
    RedirectPC = redirect_q;
    if (is_enter) begin
      RedirectPC = enter_pc;
    end else if (is_return) begin
      RedirectPC = epc;
    end
    InHandler = in_handler;
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed bench for intr_ctrl.
// Honours INTR_VECTORED_EN for the expected handler vectors.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  IntReq;
  logic        Stall;
  logic [31:0] ID_PC;
  logic        ID_InDelay;
  logic        mtc0;
  logic        eret;
  logic [4:0]  CP0_Addr;
  logic [31:0] CP0_WData;
  logic [31:0] CP0_RData;
  logic        IntFlush;
  logic        PCRedirect;
  logic [31:0] RedirectPC;
  logic        InHandler;

  int n_chk = 0;
  int n_err = 0;

`ifdef INTR_VECTORED_EN
  localparam logic [31:0] VEC_S1 = 32'h810;
  localparam logic [31:0] VEC_S2 = 32'h820;
`else
  localparam logic [31:0] VEC_S1 = 32'h800;
  localparam logic [31:0] VEC_S2 = 32'h800;
`endif

  intr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .IntReq     (IntReq),
    .Stall      (Stall),
    .ID_PC      (ID_PC),
    .ID_InDelay (ID_InDelay),
    .mtc0       (mtc0),
    .eret       (eret),
    .CP0_Addr   (CP0_Addr),
    .CP0_WData  (CP0_WData),
    .CP0_RData  (CP0_RData),
    .IntFlush   (IntFlush),
    .PCRedirect (PCRedirect),
    .RedirectPC (RedirectPC),
    .InHandler  (InHandler)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(
    input string       tag,
    input logic [4:0]  a,
    input logic [31:0] exp
  );
    CP0_Addr = a;
    #1;
    check(tag, CP0_RData, exp);
  endtask

  task automatic wr_cp0(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    mtc0      = 1'b1;
    CP0_Addr  = a;
    CP0_WData = d;
    tick();
    mtc0 = 1'b0;
  endtask

  task automatic do_return();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  initial begin
    int hits;
    rst = 1'b1; IntReq = 4'd0; Stall = 1'b0;
    ID_PC = 32'd0; ID_InDelay = 1'b0; mtc0 = 1'b0;
    eret = 1'b0; CP0_Addr = 5'd0; CP0_WData = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_flush", {31'd0, IntFlush}, 32'd0);
    check("rst_pcr", {31'd0, PCRedirect}, 32'd0);
    check("rst_rpc", RedirectPC, 32'd0);
    check("rst_inh", {31'd0, InHandler}, 32'd0);
    check("rst_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
    chk_reg("rst_status", CP0_STATUS, 32'd0);
    chk_reg("rst_epc", CP0_EPC, 32'd0);

    IntReq = 4'b1010;
    chk_reg("cause_ip", CP0_CAUSE, 32'h0000_0A00);
    wr_cp0(CP0_CAUSE, 32'hFFFF_FFFF);
    chk_reg("cause_ro", CP0_CAUSE, 32'h0000_0A00);
    chk_reg("addr15_zero", 5'd15, 32'd0);
    IntReq = 4'd0;

    // Scenario 1: basic entry
    wr_cp0(CP0_STATUS, 32'h0000_0F01);
    chk_reg("s1_status", CP0_STATUS, 32'h0000_0F01);
    ID_PC  = 32'h40;
    IntReq = 4'b0100;
    tick();
    check("s1_wait_pcr", {31'd0, PCRedirect}, 32'd0);
    tick();
    check("s1_enter_flush", {31'd0, IntFlush}, 32'd1);
    check("s1_enter_pcr", {31'd0, PCRedirect}, 32'd1);
    check("s1_enter_rpc", RedirectPC, VEC_S2);
    tick();
    check("s1_hnd_pcr", {31'd0, PCRedirect}, 32'd0);
    check("s1_hnd_inh", {31'd0, InHandler}, 32'd1);
    check("s1_hnd_rpc", RedirectPC, VEC_S2);
    chk_reg("s1_epc", CP0_EPC, 32'h40);
    chk_reg("s1_ie0", CP0_STATUS, 32'h0000_0F00);
    IntReq = 4'd0;

    // Scenario 3: return
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("s3_ret_pcr", {31'd0, PCRedirect}, 32'd1);
    check("s3_ret_flush", {31'd0, IntFlush}, 32'd1);
    check("s3_ret_rpc", RedirectPC, 32'h40);
    tick();
    check("s3_idle_pcr", {31'd0, PCRedirect}, 32'd0);
    check("s3_idle_inh", {31'd0, InHandler}, 32'd0);
    check("s3_idle_rpc", RedirectPC, 32'h40);
    check("s3_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
    chk_reg("s3_ie1", CP0_STATUS, 32'h0000_0F01);

    // Scenario 2: stall, delay slot and eret while waiting
    ID_PC  = 32'h100;
    Stall  = 1'b1;
    IntReq = 4'b0001;
    tick();
    eret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("s2_stall_flush", {31'd0, IntFlush}, 32'd0);
      tick();
    end
    Stall      = 1'b0;
    ID_InDelay = 1'b1;
    check("s2_delay_flush", {31'd0, IntFlush}, 32'd0);
    tick();
    ID_InDelay = 1'b0;
    check("s2_wait_pcr", {31'd0, PCRedirect}, 32'd0);
    check("s2_wait_state", {29'd0, dut.state}, {29'd0, ST_WAIT});
    tick();
    eret = 1'b0;
    check("s2_enter_flush", {31'd0, IntFlush}, 32'd1);
    check("s2_enter_rpc", RedirectPC, 32'h800);
    tick();
    IntReq = 4'd0;
    check("s2_hnd_inh", {31'd0, InHandler}, 32'd1);
    chk_reg("s2_epc", CP0_EPC, 32'h100);
    do_return();

    // Scenario 4: masking and priority
    wr_cp0(CP0_STATUS, 32'h0000_0201);
    ID_PC  = 32'h200;
    IntReq = 4'b0011;
    tick();
    tick();
    check("s4_enter_pcr", {31'd0, PCRedirect}, 32'd1);
    check("s4_enter_rpc", RedirectPC, VEC_S1);
    tick();
    IntReq = 4'd0;
    do_return();
    wr_cp0(CP0_STATUS, 32'h0000_0001);
    IntReq = 4'b1111;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (PCRedirect || InHandler) hits++;
    end
    check("s4_masked_hits", hits, 32'd0);
    IntReq = 4'd0;

    // Scenario 5: mtc0 Status in the ENTER cycle
    wr_cp0(CP0_STATUS, 32'h0000_0F01);
    ID_PC  = 32'h300;
    IntReq = 4'b0100;
    tick();
    tick();
    check("s5_enter_pcr", {31'd0, PCRedirect}, 32'd1);
    mtc0      = 1'b1;
    CP0_Addr  = CP0_STATUS;
    CP0_WData = 32'h1;
    tick();
    mtc0 = 1'b0;
    IntReq = 4'd0;
    chk_reg("s5_ie0", CP0_STATUS, 32'h0000_0F00);
    chk_reg("s5_epc", CP0_EPC, 32'h300);
    do_return();
    chk_reg("s5_ie_back", CP0_STATUS, 32'h0000_0F01);

    // Scenario 6: reset during ENTER
    ID_PC  = 32'h500;
    IntReq = 4'b0010;
    tick();
    tick();
    check("s6_enter_pcr", {31'd0, PCRedirect}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    IntReq = 4'd0;
    check("s6_flush", {31'd0, IntFlush}, 32'd0);
    check("s6_pcr", {31'd0, PCRedirect}, 32'd0);
    check("s6_rpc", RedirectPC, 32'd0);
    check("s6_inh", {31'd0, InHandler}, 32'd0);
    check("s6_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
    chk_reg("s6_epc", CP0_EPC, 32'd0);
    chk_reg("s6_status", CP0_STATUS, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
